char_pwm_array_gen: RTL
=======================

# char_pwm_array_gen

Parametrised pixel-pattern PWM generator feeding the neuromorphic array's input lines. It drives `NUM_PIXELS` outputs from a writable bank of `NUM_CHARS` character patterns. Each output carries a programmable-duty PWM waveform: the true waveform for "on" pixels, the complement for "off" pixels. Character, duty and tick rate switch only at frame boundaries, and an optional sequence mode auto-cycles through the bank.

## Interface
Parameters:
- `NUM_PIXELS`, 16: pixel outputs per character.
- `NUM_CHARS`, 4: pattern bank depth; power of two, ≥2.
- `DIV_WIDTH`, 20: prescaler compare width.
- `PHASE_WIDTH`, 8: PWM phase counter width; a frame is 2^PHASE_WIDTH ticks.
- `HOLD_WIDTH`, 8: sequence-mode hold counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `char_select` in log2(NUM_CHARS): static-mode character.
- `seq_en` in 1: 1 = auto-sequence, 0 = static.
- `div_cfg` in DIV_WIDTH: tick every `div_cfg+1` clocks.
- `duty_cfg` in PHASE_WIDTH: PWM high ticks per frame.
- `hold_cfg` in HOLD_WIDTH: sequence mode holds each character `hold_cfg+1` frames.
- `wr_en` in 1: pattern write strobe.
- `wr_addr` in log2(NUM_CHARS): pattern slot to write.
- `wr_data` in NUM_PIXELS: pattern bits; 1 = on pixel.
- `digit` out NUM_PIXELS: registered pixel waveforms.
- `active_char` out log2(NUM_CHARS): character currently displayed.
- `frame_start` out 1: one-cycle pulse after each frame commit.

## Operation
- Prescaler
  - `presc_cnt` increments every clock.
  - When `presc_cnt == div_q`, `tick` is asserted and `presc_cnt` clears.
  - `div_q = 0` gives a tick every clock.
- Phase
  - `phase` increments on `tick` and wraps from 2^PHASE_WIDTH-1 to 0.
  - Frame boundary `fb` = `tick && phase == max`.
- PWM base: `base = (phase < duty_q)`.
  - `duty_q = 0` gives constant 0.
  - The maximum duty gives high on all but one tick.
- Output: `digit[i] <= shadow[i] ? base : ~base`, registered every clock.
- Commit on `fb`, same edge:
  - `phase → 0`.
  - `duty_q ← duty_cfg`, `div_q ← div_cfg`.
  - `active_char ← next_char`.
  - `shadow ← bank[next_char]`.
- `next_char`
  - Static mode: `char_select`.
  - Sequence mode with `hold_cnt == hold_cfg`: `active_char+1` mod NUM_CHARS, and `hold_cnt` clears.
  - Sequence mode otherwise: `active_char`, and `hold_cnt` increments.
  - In static mode `hold_cnt` is held at 0.
- Pattern bank
  - `wr_en` writes `bank[wr_addr] ← wr_data` at any time.
  - The displayed pattern changes only at the next commit.
- Write coinciding with `fb` where `wr_addr == next_char`: `shadow` takes `wr_data` (write-through bypass).
- Mid-frame changes to `char_select`, `duty_cfg`, `div_cfg` or `seq_en` have no visible effect until the next commit. Toggling `seq_en` mid-frame only changes the `next_char` rule at the next `fb`.

## Timing
- Reset values:
  - `digit = 0`, `frame_start = 0`, `active_char = 0`.
  - `presc_cnt = 0`, `phase = 0`, `hold_cnt = 0`.
  - `div_q = 0`, `duty_q = 2^(PHASE_WIDTH-1)` (50%).
  - `bank` = package defaults; `shadow` = default pattern 0.
- First clock after `rst` falls: `digit` reflects phase 0, i.e. on pixels = 1, off pixels = 0.
- Latency:
  - `digit` lags `phase`/`shadow` by one clock.
  - `frame_start` pulses on the clock after the commit edge, aligned with the first `digit` of the new frame.
- Frame period: (div_q+1)·2^PHASE_WIDTH clocks.
- Reset asserted mid-frame: all state returns to reset values on that edge, with no partial commit. Bank writes on the reset cycle are dropped.

## Structure
- Package `char_pwm_pkg`:
  - Default 4×16 pattern constants for A, J, N, X.
  - Bank-init function that repeats the defaults modulo 4 for larger banks and zero-extends/truncates to NUM_PIXELS.
  - A clog2 helper.
- Sub-module `pwm_tick_div`: prescaler with `clk`, `rst`, `div`, `tick`.
- All remaining logic lives in the top module.

## Test plan
Use PHASE_WIDTH=4 for all scenarios.
1. Reset release with default config: `digit` toggles every 8 clocks (50%, div 0). Pattern-A on bits are high in the first 8 clocks, off bits are the complement. `frame_start` fires every 16 clocks.
2. `duty_cfg=4`, `div_cfg=1` mid-frame: the current frame is unchanged. After the next `frame_start`, on pixels are high 8 clocks and low 24 clocks, period 32.
3. `seq_en=1`, `hold_cfg=1`: `active_char` steps 0→1→2→3→0, advancing every 2 frames.
4. Write `bank[2]=16'hFFFF` while displaying char 2: `digit` is unchanged until the next commit, then all bits equal `base`.
5. `wr_en` to `next_char` on the `fb` cycle: the new frame shows `wr_data`, not the old bank contents.
6. Assert `rst` for 1 clock mid-frame: `digit=0` and `active_char=0`, `frame_start` stays low, then case 1 behaviour resumes.

Source files
------------

// File: rtl/char_pwm_pkg.sv
// Shared constants and helpers for the character PWM array generator:
// default 4x4 glyph patterns (row 0 in the MSBs) and sizing helpers.
package char_pwm_pkg;

  localparam logic [15:0] PAT_A = 16'h69F9;
  localparam logic [15:0] PAT_J = 16'h1196;
  localparam logic [15:0] PAT_N = 16'h9DB9;
  localparam logic [15:0] PAT_X = 16'h9669;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while (((32'd1 << r) < n) && (r < 31)) r++;
    return r;
  endfunction

  // Pixel px of default slot ch; defaults repeat every 4 slots, pixels beyond 16 read as 0.
  function automatic logic bank_init_bit(input int unsigned ch, input int unsigned px);
    logic [15:0] pat;
    case (ch[1:0])
      2'd0:    pat = PAT_A;
      2'd1:    pat = PAT_J;
      2'd2:    pat = PAT_N;
      default: pat = PAT_X;
    endcase
    return (px < 16) ? pat[px[3:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/char_pwm_array_gen_tick_div.sv
// Prescaler: emits a one-clock tick every div+1 clocks.
module pwm_tick_div
  import char_pwm_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] presc_cnt;

  assign tick = (presc_cnt == div);

  always_ff @(posedge clk) begin
    if (rst)       presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else           presc_cnt <= presc_cnt + 1'b1;
  end

endmodule

// File: rtl/char_pwm_array_gen.sv
// Pixel-pattern PWM generator: each output carries the PWM waveform (on pixel)
// or its complement (off pixel); all display settings commit at frame boundaries.
module char_pwm_array_gen
  import char_pwm_pkg::*;
#(
  parameter int unsigned NUM_PIXELS  = 16,
  parameter int unsigned NUM_CHARS   = 4,
  parameter int unsigned DIV_WIDTH   = 20,
  parameter int unsigned PHASE_WIDTH = 8,
  parameter int unsigned HOLD_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [clog2(NUM_CHARS)-1:0]   char_select,
  input  logic                          seq_en,
  input  logic [DIV_WIDTH-1:0]          div_cfg,
  input  logic [PHASE_WIDTH-1:0]        duty_cfg,
  input  logic [HOLD_WIDTH-1:0]         hold_cfg,
  input  logic                          wr_en,
  input  logic [clog2(NUM_CHARS)-1:0]   wr_addr,
  input  logic [NUM_PIXELS-1:0]         wr_data,
  output logic [NUM_PIXELS-1:0]         digit,
  output logic [clog2(NUM_CHARS)-1:0]   active_char,
  output logic                          frame_start
);

  localparam int unsigned CW = clog2(NUM_CHARS);
  localparam logic [PHASE_WIDTH-1:0] DUTY_RST = {1'b1, {(PHASE_WIDTH-1){1'b0}}};

  function automatic logic [NUM_PIXELS-1:0] init_word(input int unsigned ch);
    logic [NUM_PIXELS-1:0] w;
    w = '0;
    for (int unsigned p = 0; p < NUM_PIXELS; p++) w[p] = bank_init_bit(ch, p);
    return w;
  endfunction

  logic [NUM_PIXELS-1:0]  bank [NUM_CHARS];
  logic [NUM_PIXELS-1:0]  shadow, next_shadow;
  logic [PHASE_WIDTH-1:0] phase, duty_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [HOLD_WIDTH-1:0]  hold_cnt, hold_next;
  logic [CW-1:0]          next_char;
  logic                   tick, fb, base, commit_d;

  pwm_tick_div #(.DIV_WIDTH(DIV_WIDTH)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .div  (div_q),
    .tick (tick)
  );

  assign fb = tick && (phase == '1);

  always_comb begin
    next_char = active_char;
    hold_next = hold_cnt;
    if (!seq_en) begin
      next_char = char_select;
      hold_next = '0;
    end else if (hold_cnt == hold_cfg) begin
      next_char = active_char + 1'b1;
      hold_next = '0;
    end else begin
      hold_next = hold_cnt + 1'b1;
    end
    // Write-through so a write landing on the commit edge is not lost for a frame.
    next_shadow = (wr_en && (wr_addr == next_char)) ? wr_data : bank[next_char];
    base        = (phase < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CHARS; c++) bank[CW'(c)] <= init_word(c);
    end else if (wr_en) begin
      bank[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      duty_q      <= DUTY_RST;
      div_q       <= '0;
      active_char <= '0;
      shadow      <= init_word(0);
      hold_cnt    <= '0;
      digit       <= '0;
      commit_d    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      digit       <= base ? shadow : ~shadow;
      // Two stages so the pulse lines up with the first digit of the new frame.
      commit_d    <= fb;
      frame_start <= commit_d;
      if (fb) begin
        phase       <= '0;
        duty_q      <= duty_cfg;
        div_q       <= div_cfg;
        active_char <= next_char;
        shadow      <= next_shadow;
        hold_cnt    <= hold_next;
      end else if (tick) begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule
